// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles SOF/LEN/payload/CHK frames from the uart_rx
// character strobe stream. Each payload is buffered until its parity and
// checksum checks pass, then released over a valid/ready stream.
// Malformed frames are dropped and reported through frm_err/err_code.
module uart_frame_parser #(
  parameter int                    DATA_WIDTH = 7,
  parameter int                    MAX_LEN    = 16,
  parameter logic [DATA_WIDTH-1:0] SOF        = 7'h55,
  parameter int                    TIMEOUT    = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_vld,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_prity_vld,
  output logic                  out_vld,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_rdy,
  output logic                  frm_ok,
  output logic                  frm_err,
  output logic [2:0]            err_code,
  output logic                  busy
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [DATA_WIDTH-1:0] MAX_LEN_C = DATA_WIDTH'(MAX_LEN);
  localparam logic [DATA_WIDTH-1:0] ZERO_C    = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONE_C     = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [TMR_W-1:0]      TIMEOUT_C = TMR_W'(TIMEOUT);
  localparam logic [IDX_W-1:0]      IDX0_C    = {IDX_W{1'b0}};

  localparam logic [2:0] ERR_PARITY  = 3'd1;
  localparam logic [2:0] ERR_LEN     = 3'd2;
  localparam logic [2:0] ERR_CHKSUM  = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_OVERRUN = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_DRAIN   = 3'd4
  } state_t;

  // Checksum accumulation: modulo 2^DATA_WIDTH, carries discarded.
  function automatic logic [DATA_WIDTH-1:0] sum_add(input logic [DATA_WIDTH-1:0] a,
                                                    input logic [DATA_WIDTH-1:0] b);
    return a + b;
  endfunction

  state_t                state_r;
  logic [DATA_WIDTH-1:0] len_r;
  logic [DATA_WIDTH-1:0] sum_r;
  logic [DATA_WIDTH-1:0] wr_idx_r;
  logic [DATA_WIDTH-1:0] rd_idx_r;
  logic [TMR_W-1:0]      timer_r;
  logic [DATA_WIDTH-1:0] buf_r [MAX_LEN];
  logic                  out_vld_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_last_r;
  logic                  frm_ok_r;
  logic                  frm_err_r;
  logic [2:0]            err_code_r;
  logic                  busy_r;

  logic                  wr_en_s;
  logic                  xfer_s;
  logic [DATA_WIDTH-1:0] rd_nxt_s;

  assign out_vld  = out_vld_r;
  assign out_data = out_data_r;
  assign out_last = out_last_r;
  assign frm_ok   = frm_ok_r;
  assign frm_err  = frm_err_r;
  assign err_code = err_code_r;
  assign busy     = busy_r;

  // Buffer write enable, output handshake and next read index.
  always_comb begin
    wr_en_s  = 1'b0;
    xfer_s   = out_vld_r & out_rdy;
    rd_nxt_s = rd_idx_r + ONE_C;
    if ((state_r == ST_PAYLOAD) && in_vld && in_prity_vld) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Payload storage: written only in PAYLOAD, read only in DRAIN.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_r[wr_idx_r[IDX_W-1:0]] <= in_data;
    end
  end

  // Frame FSM with registered stream outputs, pulses and error code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      len_r      <= ZERO_C;
      sum_r      <= ZERO_C;
      wr_idx_r   <= ZERO_C;
      rd_idx_r   <= ZERO_C;
      timer_r    <= {TMR_W{1'b0}};
      out_vld_r  <= 1'b0;
      out_data_r <= ZERO_C;
      out_last_r <= 1'b0;
      frm_ok_r   <= 1'b0;
      frm_err_r  <= 1'b0;
      err_code_r <= 3'd0;
      busy_r     <= 1'b0;
    end else begin
      frm_ok_r  <= 1'b0;
      frm_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          timer_r <= {TMR_W{1'b0}};
          if (in_vld && in_prity_vld && (in_data == SOF)) begin
            state_r <= ST_LEN;
            busy_r  <= 1'b1;
          end
        end
        ST_LEN, ST_PAYLOAD, ST_CHK: begin
          if (in_vld) begin
            timer_r <= {TMR_W{1'b0}};
            if (!in_prity_vld) begin
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              frm_err_r  <= 1'b1;
              err_code_r <= ERR_PARITY;
            end else begin
              case (state_r)
                ST_LEN: begin
                  if ((in_data == ZERO_C) || (in_data > MAX_LEN_C)) begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    frm_err_r  <= 1'b1;
                    err_code_r <= ERR_LEN;
                  end else begin
                    len_r    <= in_data;
                    sum_r    <= in_data;
                    wr_idx_r <= ZERO_C;
                    state_r  <= ST_PAYLOAD;
                  end
                end
                ST_PAYLOAD: begin
                  sum_r    <= sum_add(sum_r, in_data);
                  wr_idx_r <= wr_idx_r + ONE_C;
                  if ((wr_idx_r + ONE_C) == len_r) begin
                    state_r <= ST_CHK;
                  end
                end
                ST_CHK: begin
                  if (in_data == sum_r) begin
                    frm_ok_r   <= 1'b1;
                    rd_idx_r   <= ZERO_C;
                    out_vld_r  <= 1'b1;
                    out_data_r <= buf_r[IDX0_C];
                    out_last_r <= (len_r == ONE_C);
                    state_r    <= ST_DRAIN;
                  end else begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    frm_err_r  <= 1'b1;
                    err_code_r <= ERR_CHKSUM;
                  end
                end
                default: begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
                end
              endcase
            end
          end else if (timer_r == TIMEOUT_C) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            frm_err_r  <= 1'b1;
            err_code_r <= ERR_TIMEOUT;
          end else begin
            timer_r <= timer_r + 1'b1;
          end
        end
        ST_DRAIN: begin
          // A character arriving while draining is dropped, never parsed.
          if (in_vld) begin
            frm_err_r  <= 1'b1;
            err_code_r <= ERR_OVERRUN;
          end
          if (xfer_s) begin
            if (out_last_r) begin
              state_r    <= ST_IDLE;
              busy_r     <= 1'b0;
              out_vld_r  <= 1'b0;
              out_last_r <= 1'b0;
            end else begin
              rd_idx_r   <= rd_nxt_s;
              out_data_r <= buf_r[rd_nxt_s[IDX_W-1:0]];
              out_last_r <= (rd_nxt_s == (len_r - ONE_C));
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          busy_r    <= 1'b0;
          out_vld_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed self-checking bench for uart_frame_parser.
module tb_uart_frame_parser;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_vld;
  logic [6:0] in_data;
  logic       in_prity_vld;
  logic       out_vld;
  logic [6:0] out_data;
  logic       out_last;
  logic       out_rdy;
  logic       frm_ok;
  logic       frm_err;
  logic [2:0] err_code;
  logic       busy;

  int checks  = 0;
  int errors  = 0;
  int ok_cnt  = 0;
  int err_cnt = 0;
  int e0;
  logic [6:0] exp_q [$];

  uart_frame_parser #(
    .DATA_WIDTH(7),
    .MAX_LEN(16),
    .SOF(7'h55),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_vld(in_vld),
    .in_data(in_data),
    .in_prity_vld(in_prity_vld),
    .out_vld(out_vld),
    .out_data(out_data),
    .out_last(out_last),
    .out_rdy(out_rdy),
    .frm_ok(frm_ok),
    .frm_err(frm_err),
    .err_code(err_code),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled away from the active edge.
  always @(negedge clk) begin
    if (frm_ok)  ok_cnt  <= ok_cnt + 1;
    if (frm_err) err_cnt <= err_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] d, input logic p);
    in_vld       = 1'b1;
    in_data      = d;
    in_prity_vld = p;
    step();
    in_vld       = 1'b0;
    in_prity_vld = 1'b1;
  endtask

  // Drain the expected characters in exp_q with a repeating out_rdy pattern;
  // optionally inject a character at drain cycle inject_at.
  task automatic drain(input int n, input logic [3:0] pat, input int inject_at);
    int k   = 0;
    int cyc = 0;
    while (k < n && cyc < 200) begin
      out_rdy      = pat[cyc % 4];
      in_vld       = (cyc == inject_at);
      in_data      = 7'h55;
      in_prity_vld = 1'b1;
      check("drain_vld", {31'd0, out_vld}, 32'd1);
      check("drain_data", {25'd0, out_data}, {25'd0, exp_q[k]});
      check("drain_last", {31'd0, out_last}, {31'd0, (k == n - 1)});
      if (out_vld && out_rdy) k++;
      step();
      in_vld = 1'b0;
      cyc++;
    end
    check("drain_budget", {31'd0, (cyc < 200)}, 32'd1);
    out_rdy = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_vld = 1'b0; in_data = 7'h00; in_prity_vld = 1'b1; out_rdy = 1'b1;
    step(); step();
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_data", {25'd0, out_data}, 32'd0);
    check("rst_frm_ok", {31'd0, frm_ok}, 32'd0);
    check("rst_frm_err", {31'd0, frm_err}, 32'd0);
    check("rst_err_code", {29'd0, err_code}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    step();

    // Good frame 55 02 10 20 32.
    send(7'h55, 1'b1);
    check("good_busy", {31'd0, busy}, 32'd1);
    send(7'h02, 1'b1); send(7'h10, 1'b1); send(7'h20, 1'b1); send(7'h32, 1'b1);
    check("good_ok", {31'd0, frm_ok}, 32'd1);
    check("good_noerr", {31'd0, frm_err}, 32'd0);
    exp_q = '{7'h10, 7'h20};
    drain(2, 4'b1111, -1);
    check("good_vld_low", {31'd0, out_vld}, 32'd0);
    check("good_idle", {31'd0, busy}, 32'd0);
    check("good_ok_cnt", ok_cnt, 32'd1);
    check("good_err_cnt", err_cnt, 32'd0);

    // Checksum error, then 55 01 7F 00.
    send(7'h55, 1'b1); send(7'h02, 1'b1); send(7'h10, 1'b1); send(7'h20, 1'b1); send(7'h33, 1'b1);
    check("chk_err", {31'd0, frm_err}, 32'd1);
    check("chk_code", {29'd0, err_code}, 32'd3);
    check("chk_novld", {31'd0, out_vld}, 32'd0);
    check("chk_idle", {31'd0, busy}, 32'd0);
    send(7'h55, 1'b1); send(7'h01, 1'b1); send(7'h7F, 1'b1); send(7'h00, 1'b1);
    check("wrap_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = '{7'h7F};
    drain(1, 4'b1111, -1);
    check("wrap_idle", {31'd0, busy}, 32'd0);

    // Bad LEN values.
    send(7'h55, 1'b1); send(7'h00, 1'b1);
    check("len0_err", {31'd0, frm_err}, 32'd1);
    check("len0_code", {29'd0, err_code}, 32'd2);
    check("len0_idle", {31'd0, busy}, 32'd0);
    send(7'h55, 1'b1); send(7'h11, 1'b1);
    check("len17_err", {31'd0, frm_err}, 32'd1);
    check("len17_code", {29'd0, err_code}, 32'd2);

    // Maximum length frame: payload 1..16, CHK 0x18.
    send(7'h55, 1'b1); send(7'h10, 1'b1);
    check("len16_noerr", {31'd0, frm_err}, 32'd0);
    check("len16_busy", {31'd0, busy}, 32'd1);
    exp_q = {};
    for (int i = 1; i <= 16; i++) begin
      send(7'(i), 1'b1);
      exp_q.push_back(7'(i));
    end
    send(7'h18, 1'b1);
    check("len16_ok", {31'd0, frm_ok}, 32'd1);
    drain(16, 4'b1111, -1);
    check("len16_idle", {31'd0, busy}, 32'd0);

    // Parity error mid-frame.
    send(7'h55, 1'b1); send(7'h03, 1'b1); send(7'h01, 1'b1); send(7'h02, 1'b0);
    check("par_err", {31'd0, frm_err}, 32'd1);
    check("par_code", {29'd0, err_code}, 32'd1);
    check("par_idle", {31'd0, busy}, 32'd0);

    // Noise in IDLE, including an SOF with bad parity.
    step();
    e0 = err_cnt;
    send(7'h12, 1'b1); send(7'h34, 1'b1); send(7'h55, 1'b0);
    step();
    check("noise_idle", {31'd0, busy}, 32'd0);
    check("noise_nopulse", err_cnt, e0);

    // Timeout: error exactly TO+1 cycles after the last strobe.
    send(7'h55, 1'b1); send(7'h02, 1'b1); send(7'h10, 1'b1);
    repeat (TO) step();
    check("to_early", {31'd0, frm_err}, 32'd0);
    check("to_busy", {31'd0, busy}, 32'd1);
    step();
    check("to_err", {31'd0, frm_err}, 32'd1);
    check("to_code", {29'd0, err_code}, 32'd4);
    check("to_idle", {31'd0, busy}, 32'd0);

    // Character on the expiry cycle wins.
    send(7'h55, 1'b1); send(7'h02, 1'b1); send(7'h10, 1'b1);
    repeat (TO) step();
    send(7'h20, 1'b1);
    check("to_edge_noerr", {31'd0, frm_err}, 32'd0);
    check("to_edge_busy", {31'd0, busy}, 32'd1);
    send(7'h32, 1'b1);
    check("to_edge_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = '{7'h10, 7'h20};
    drain(2, 4'b1111, -1);

    // Backpressure with an overrun injected during a stall.
    e0 = err_cnt;
    send(7'h55, 1'b1); send(7'h04, 1'b1);
    send(7'h01, 1'b1); send(7'h02, 1'b1); send(7'h03, 1'b1); send(7'h04, 1'b1);
    send(7'h0E, 1'b1);
    check("bp_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = '{7'h01, 7'h02, 7'h03, 7'h04};
    drain(4, 4'b1001, 2);
    check("bp_vld_low", {31'd0, out_vld}, 32'd0);
    check("bp_idle", {31'd0, busy}, 32'd0);
    check("ovr_code", {29'd0, err_code}, 32'd5);
    check("ovr_cnt", err_cnt, e0 + 1);

    // Reset mid-PAYLOAD.
    send(7'h55, 1'b1); send(7'h03, 1'b1); send(7'h01, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstp_busy", {31'd0, busy}, 32'd0);
    check("rstp_err_code", {29'd0, err_code}, 32'd0);
    check("rstp_frm_err", {31'd0, frm_err}, 32'd0);
    step();
    rst = 1'b0;

    // Reset mid-DRAIN.
    send(7'h55, 1'b1); send(7'h02, 1'b1); send(7'h0A, 1'b1); send(7'h0B, 1'b1); send(7'h17, 1'b1);
    check("rstd_ok", {31'd0, frm_ok}, 32'd1);
    out_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstd_vld", {31'd0, out_vld}, 32'd0);
    check("rstd_data", {25'd0, out_data}, 32'd0);
    check("rstd_frm_ok", {31'd0, frm_ok}, 32'd0);
    check("rstd_busy", {31'd0, busy}, 32'd0);
    step();
    rst = 1'b0;
    out_rdy = 1'b1;
    send(7'h55, 1'b1); send(7'h01, 1'b1); send(7'h05, 1'b1); send(7'h06, 1'b1);
    check("post_rst_ok", {31'd0, frm_ok}, 32'd1);
    exp_q = '{7'h05};
    drain(1, 4'b1111, -1);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_frame_parser.md
# uart_frame_parser

Framing stage directly downstream of `uart_rx` in the UART loopback design. It consumes the per-character `done`/`data_pkg`/`prity_vld` strobe stream and recognises frames of the form SOF, LEN, LEN payload characters, CHK. It buffers each payload internally and releases it over a valid/ready stream only after the parity and checksum checks pass. Malformed frames are dropped and reported with an error code.

## Interface
- `DATA_WIDTH`, 7: character width; matches `uart_rx`.
- `MAX_LEN`, 16: maximum payload characters per frame, 1..2^DATA_WIDTH-1.
- `SOF`, 7'h55: start-of-frame character.
- `TIMEOUT`, 4096: inter-character timeout in `clk` cycles, ≥2.

- `clk`  in  1  the single clock (the `uart_rx` clock).
- `rst`  in  1  asynchronous, active-high reset.
- `in_vld`  in  1  one-cycle strobe per received character (`uart_rx` `done`).
- `in_data`  in  DATA_WIDTH  received character, sampled when `in_vld`=1.
- `in_prity_vld`  in  1  parity good for the character, sampled with `in_vld`.
- `out_vld`  out  1  payload character available.
- `out_data`  out  DATA_WIDTH  payload character.
- `out_last`  out  1  final payload character of the frame; qualified by `out_vld`.
- `out_rdy`  in  1  consumer accepts; a transfer occurs when `out_vld` and `out_rdy` are both 1.
- `frm_ok`  out  1  one-cycle pulse: the frame passed its checks.
- `frm_err`  out  1  one-cycle pulse: a frame was dropped, or a character arrived during drain.
- `err_code`  out  3  updated with each `frm_err` and held until the next one. Codes: 1 = parity, 2 = bad LEN, 3 = checksum, 4 = timeout, 5 = overrun.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE → LEN on an `in_vld` carrying `in_data`==SOF with parity good. Any other character in IDLE, including one with a parity error, is discarded silently.
  - LEN:
    - LEN of 0 or greater than MAX_LEN → `frm_err` with code 2, go to IDLE.
    - Otherwise store LEN, initialise sum=LEN and wr_idx=0, go to PAYLOAD.
  - PAYLOAD: for each character, write buf[wr_idx], add it to sum, increment wr_idx. When wr_idx reaches LEN, go to CHK.
  - CHK:
    - CHK == sum → `frm_ok`, set rd_idx=0, go to DRAIN.
    - Otherwise `frm_err` with code 3, go to IDLE.
  - DRAIN:
    - `out_vld`=1 and `out_data`=buf[rd_idx].
    - `out_last`=1 when rd_idx==LEN-1.
    - A transfer increments rd_idx. The transfer with `out_last`=1 returns the block to IDLE.
- Sum rule: modulo 2^DATA_WIDTH over LEN and all payload characters; carries are discarded. The received SOF character is not included.
- Parity: an `in_vld` with `in_prity_vld`=0 while in LEN, PAYLOAD or CHK → `frm_err` with code 1, go to IDLE.
- Timeout:
  - A timer runs only in LEN, PAYLOAD and CHK. It increments on each cycle with `in_vld`=0 and is cleared by `in_vld` and on state entry.
  - When it reaches TIMEOUT, the next cycle raises `frm_err` with code 4 and the block goes to IDLE.
  - If `in_vld` arrives on the same cycle the timer would expire, the character wins.
- Overrun: an `in_vld` during DRAIN → the character is discarded and `frm_err` pulses with code 5. Draining continues and the buffer is untouched. The character is not examined for SOF.
- Buffer: MAX_LEN×DATA_WIDTH register array with a single writer (PAYLOAD) and a single reader (DRAIN); the two never overlap.

## Timing
- Reset (asynchronous): state IDLE, all counters 0; `out_vld`, `out_last`, `frm_ok`, `frm_err`, `busy` = 0; `err_code`=0; `out_data`=0. Reset asserted mid-frame or mid-drain aborts immediately; the partial frame is lost and no pulse is generated.
- State transitions, `frm_ok`, `frm_err` and `err_code` are registered and appear in the cycle after the triggering `in_vld` cycle.
- `frm_ok` rises in the same cycle that `out_vld` first rises.
- `out_data`, `out_last` and `out_vld` are stable while `out_vld`=1 and `out_rdy`=0.
- Back-to-back transfers are possible: one character per cycle with `out_rdy` held at 1. The minimum drain is LEN cycles.
- `out_vld` falls in the cycle after the `out_last` transfer. An SOF character arriving in that same cycle is accepted normally because the state is IDLE.
- `frm_ok` and `frm_err` are never asserted in the same cycle.

## Test plan
- Good frame: 55, 02, 10, 20, 32 with `out_rdy`=1 → `frm_ok` pulses once; the stream is 10, then 20 with `out_last`=1; `busy` returns to 0; no `frm_err`.
- Checksum error: 55, 02, 10, 20, 33 → `frm_err` with `err_code`=3, no `out_vld`, IDLE. A following good frame 55, 01, 7F, 00 (sum 0x80 mod 128 = 0) → `frm_ok`, stream 7F with `out_last`=1.
- Length and parity: LEN=00 → code 2; LEN=17 with MAX_LEN=16 → code 2. Frame 55, 03, 01 with a parity-bad character next → code 1. Noise bytes 12, 34 in IDLE → no pulse.
- Timeout: 55, 02, 10, then silence → `frm_err` with code 4 exactly TIMEOUT+1 cycles after the 10 strobe. A repeat where a character lands on the expiry cycle → no error.
- Backpressure and overrun: good 4-character frame with `out_rdy` toggling 1,0,0,1,… → order and `out_last` are preserved and `out_data` is stable during stalls. An `in_vld` injected during DRAIN → code 5 and the drain still completes.
- Reset mid-PAYLOAD and mid-DRAIN → outputs are 0 immediately; the next good frame parses correctly.
